// File: rtl/mc_ctrl_defs.sv
// Shared encodings for the multicycle control unit: opcodes, FSM states, ALU and mux-select codes.
// Pure definitions; no logic, no latency, no flow control.
package mc_ctrl_defs;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   // S_TRAP is only reachable when the illegal-op trap is built in.
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_TRAP     = 4'd11
   } state_t;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic       ADR_PC     = 1'b0;
   localparam logic       ADR_ALUOUT = 1'b1;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/mc_instr_deco.sv
// Immediate-format and ALU-operation decode from the IR fields and the FSM's aluOp.
// Purely combinational, zero latency; no flow control.
module mc_instr_deco
   import mc_ctrl_defs::*;
(
   input  logic [6:0] op,
   input  logic [2:0] f3,
   input  logic [6:0] f7,
   input  logic [1:0] aluOp,
   output logic [1:0] immSrc,
   output logic [2:0] aluControl
);

   logic subType;
   logic unusedF7;

   // Only I-ALU has op[5]=0, so addi with imm[10]=1 still adds.
   assign subType  = op[5] & f7[5];
   assign unusedF7 = ^{f7[6], f7[4:0]};

   always_comb begin
      immSrc = IMM_I;
      case (op)
         OP_SW:   immSrc = IMM_S;
         OP_BEQ:  immSrc = IMM_B;
         OP_JAL:  immSrc = IMM_J;
         default: immSrc = IMM_I;
      endcase
   end

   always_comb begin
      aluControl = ALU_ADD;
      case (aluOp)
         ALUOP_SUB: aluControl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (f3)
               3'b000:  aluControl = subType ? ALU_SUB : ALU_ADD;
               3'b010:  aluControl = ALU_SLT;
               3'b110:  aluControl = ALU_OR;
               3'b111:  aluControl = ALU_AND;
               default: aluControl = ALU_ADD;
            endcase
         end
         default: aluControl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Moore control FSM for the multicycle RISC-V datapath; 2-5 cycles per instruction, no stall input.
// Build with MC_CTRL_ILLEGAL_TRAP_EN to park in TRAP (illegalOp=1) on an unknown opcode until reset.
module mc_control_fsm
   import mc_ctrl_defs::*;
#(
   parameter int STATE_W = 4
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] f3,
   input  logic [6:0] f7,
   input  logic       zero,
   output logic       pcWrite,
   output logic       adrSrc,
   output logic       memWrite,
   output logic       irWrite,
   output logic [1:0] resultSrc,
   output logic [1:0] aluSrcA,
   output logic [1:0] aluSrcB,
   output logic       regWrite,
   output logic [1:0] immSrc,
   output logic [2:0] aluControl,
   output logic       illegalOp
);

   localparam logic [STATE_W-1:0] ST_FETCH = STATE_W'(S_FETCH);

   logic [STATE_W-1:0] stateQ;
   logic [STATE_W-1:0] stateD;
   logic [STATE_W-1:0] decState;
   logic               pcUpdate;
   logic               branch;
   logic               memWr;
   logic               irWr;
   logic               regWr;
   logic [1:0]         aluOp;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   logic               trapFlag;
`endif

   always_ff @(posedge clk) begin
      if (reset) stateQ <= ST_FETCH;
      else       stateQ <= stateD;
   end

   // Decoding FETCH during reset makes the non-enable outputs settle immediately.
   assign decState = reset ? ST_FETCH : stateQ;

   always_comb begin
      stateD    = ST_FETCH;
      pcUpdate  = 1'b0;
      branch    = 1'b0;
      adrSrc    = ADR_PC;
      memWr     = 1'b0;
      irWr      = 1'b0;
      regWr     = 1'b0;
      resultSrc = RES_ALUOUT;
      aluSrcA   = SRCA_PC;
      aluSrcB   = SRCB_RS2;
      aluOp     = ALUOP_ADD;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      trapFlag  = 1'b0;
`endif
      case (decState)
         STATE_W'(S_FETCH): begin
            irWr      = 1'b1;
            aluSrcB   = SRCB_FOUR;
            resultSrc = RES_ALURESULT;
            pcUpdate  = 1'b1;
            stateD    = STATE_W'(S_DECODE);
         end
         STATE_W'(S_DECODE): begin
            aluSrcA = SRCA_OLDPC;
            aluSrcB = SRCB_IMM;
            case (op)
               OP_LW, OP_SW: stateD = STATE_W'(S_MEMADR);
               OP_R:         stateD = STATE_W'(S_EXECUTER);
               OP_I:         stateD = STATE_W'(S_EXECUTEI);
               OP_BEQ:       stateD = STATE_W'(S_BEQ);
               OP_JAL:       stateD = STATE_W'(S_JAL);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
               default:      stateD = STATE_W'(S_TRAP);
`else
               default:      stateD = ST_FETCH;
`endif
            endcase
         end
         STATE_W'(S_MEMADR): begin
            aluSrcA = SRCA_RS1;
            aluSrcB = SRCB_IMM;
            stateD  = (op == OP_LW) ? STATE_W'(S_MEMREAD) : STATE_W'(S_MEMWRITE);
         end
         STATE_W'(S_MEMREAD): begin
            adrSrc = ADR_ALUOUT;
            stateD = STATE_W'(S_MEMWB);
         end
         STATE_W'(S_MEMWB): begin
            resultSrc = RES_DATA;
            regWr     = 1'b1;
         end
         STATE_W'(S_MEMWRITE): begin
            adrSrc = ADR_ALUOUT;
            memWr  = 1'b1;
         end
         STATE_W'(S_EXECUTER): begin
            aluSrcA = SRCA_RS1;
            aluOp   = ALUOP_FUNCT;
            stateD  = STATE_W'(S_ALUWB);
         end
         STATE_W'(S_EXECUTEI): begin
            aluSrcA = SRCA_RS1;
            aluSrcB = SRCB_IMM;
            aluOp   = ALUOP_FUNCT;
            stateD  = STATE_W'(S_ALUWB);
         end
         STATE_W'(S_ALUWB): begin
            regWr = 1'b1;
         end
         STATE_W'(S_BEQ): begin
            aluSrcA = SRCA_RS1;
            aluOp   = ALUOP_SUB;
            branch  = 1'b1;
         end
         // ALU forms oldPC+4 as the link value while the PC takes the target from ALUOut.
         STATE_W'(S_JAL): begin
            aluSrcA  = SRCA_OLDPC;
            aluSrcB  = SRCB_FOUR;
            pcUpdate = 1'b1;
            stateD   = STATE_W'(S_ALUWB);
         end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
         STATE_W'(S_TRAP): begin
            trapFlag = 1'b1;
            stateD   = STATE_W'(S_TRAP);
         end
`endif
         default: stateD = ST_FETCH;
      endcase
   end

   assign pcWrite  = ~reset & (pcUpdate | (branch & zero));
   assign memWrite = ~reset & memWr;
   assign irWrite  = ~reset & irWr;
   assign regWrite = ~reset & regWr;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   assign illegalOp = trapFlag;
`else
   assign illegalOp = 1'b0;
`endif

   mc_instr_deco uDeco (
      .op         (op),
      .f3         (f3),
      .f7         (f7),
      .aluOp      (aluOp),
      .immSrc     (immSrc),
      .aluControl (aluControl)
   );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed cycle-by-cycle check of every control output for each instruction class, reset and unknown op.
module tb_mc_control_fsm;

   logic       clk;
   logic       reset;
   logic [6:0] op;
   logic [2:0] f3;
   logic [6:0] f7;
   logic       zero;
   logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, illegalOp;
   logic [1:0] resultSrc, aluSrcA, aluSrcB, immSrc;
   logic [2:0] aluControl;

   int checks = 0;
   int errors = 0;

   mc_control_fsm #(.STATE_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .f3         (f3),
      .f7         (f7),
      .zero       (zero),
      .pcWrite    (pcWrite),
      .adrSrc     (adrSrc),
      .memWrite   (memWrite),
      .irWrite    (irWrite),
      .resultSrc  (resultSrc),
      .aluSrcA    (aluSrcA),
      .aluSrcB    (aluSrcB),
      .regWrite   (regWrite),
      .immSrc     (immSrc),
      .aluControl (aluControl),
      .illegalOp  (illegalOp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [16:0] outVec;
   assign outVec = {pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB,
                    regWrite, immSrc, aluControl, illegalOp};

   function automatic logic [16:0] ev(input logic pcW, input logic adr, input logic mw,
                                      input logic ir, input logic [1:0] rs, input logic [1:0] asa,
                                      input logic [1:0] asb, input logic rw, input logic [1:0] imm,
                                      input logic [2:0] ac, input logic ill);
      return {pcW, adr, mw, ir, rs, asa, asb, rw, imm, ac, ill};
   endfunction

   function automatic logic [16:0] fetchV(input logic [1:0] imm);
      return ev(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 1'b0, imm, 3'b000, 1'b0);
   endfunction

   function automatic logic [16:0] decodeV(input logic [1:0] imm);
      return ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0, imm, 3'b000, 1'b0);
   endfunction

   function automatic logic [16:0] aluwbV(input logic [1:0] imm);
      return ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, imm, 3'b000, 1'b0);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Sample mid-cycle, then advance to just past the next rising edge.
   task automatic cyc(input string tag, input logic [16:0] exp);
      @(negedge clk);
      check(tag, {15'd0, outVec}, {15'd0, exp});
      @(posedge clk);
      #1;
   endtask

   logic [2:0] iF3 [5] = '{3'b110, 3'b111, 3'b010, 3'b000, 3'b001};
   logic [6:0] iF7 [5] = '{7'h00, 7'h00, 7'h00, 7'h20, 7'h00};
   logic [2:0] iAc [5] = '{3'b011, 3'b010, 3'b101, 3'b000, 3'b000};

   initial begin
      reset = 1'b1;
      op    = 7'b0000011;
      f3    = 3'b000;
      f7    = 7'h00;
      zero  = 1'b0;

      @(posedge clk);
      #1;
      cyc("rst_hold", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 1'b0, 2'b00, 3'b000, 1'b0));
      reset = 1'b0;

      // lw: 5 cycles
      cyc("lw_fetch", fetchV(2'b00));
      cyc("lw_decode", decodeV(2'b00));
      cyc("lw_memadr", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0, 2'b00, 3'b000, 1'b0));
      cyc("lw_memread", ev(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0));
      cyc("lw_memwb", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 2'b00, 3'b000, 1'b0));

      // R-type sub then add
      op = 7'b0110011; f3 = 3'b000; f7 = 7'b0100000;
      cyc("sub_fetch", fetchV(2'b00));
      cyc("sub_decode", decodeV(2'b00));
      cyc("sub_exec", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 2'b00, 3'b001, 1'b0));
      cyc("sub_aluwb", aluwbV(2'b00));
      f7 = 7'h00;
      cyc("add_fetch", fetchV(2'b00));
      cyc("add_decode", decodeV(2'b00));
      cyc("add_exec", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0));
      cyc("add_aluwb", aluwbV(2'b00));

      // I-ALU f3 variants, including f7[5]=1 on addi still adding
      op = 7'b0010011;
      for (int i = 0; i < 5; i++) begin
         f3 = iF3[i]; f7 = iF7[i];
         cyc("iop_fetch", fetchV(2'b00));
         cyc("iop_decode", decodeV(2'b00));
         cyc("iop_exec", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0, 2'b00, iAc[i], 1'b0));
         cyc("iop_aluwb", aluwbV(2'b00));
      end

      // beq taken then not taken: 3 cycles each
      op = 7'b1100011; f3 = 3'b000; f7 = 7'h00; zero = 1'b1;
      cyc("beqt_fetch", fetchV(2'b10));
      cyc("beqt_decode", decodeV(2'b10));
      cyc("beqt_beq", ev(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 2'b10, 3'b001, 1'b0));
      zero = 1'b0;
      cyc("beqn_fetch", fetchV(2'b10));
      cyc("beqn_decode", decodeV(2'b10));
      cyc("beqn_beq", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 2'b10, 3'b001, 1'b0));

      // sw: 4 cycles
      op = 7'b0100011;
      cyc("sw_fetch", fetchV(2'b01));
      cyc("sw_decode", decodeV(2'b01));
      cyc("sw_memadr", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0, 2'b01, 3'b000, 1'b0));
      cyc("sw_memwrite", ev(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 3'b000, 1'b0));

      // jal: 4 cycles
      op = 7'b1101111;
      cyc("jal_fetch", fetchV(2'b11));
      cyc("jal_decode", decodeV(2'b11));
      cyc("jal_jal", ev(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0, 2'b11, 3'b000, 1'b0));
      cyc("jal_aluwb", aluwbV(2'b11));

      // sw abandoned by reset during MEMADR: no memWrite, FETCH afterwards
      op = 7'b0100011;
      cyc("swrst_fetch", fetchV(2'b01));
      cyc("swrst_decode", decodeV(2'b01));
      reset = 1'b1;
      cyc("swrst_memadr", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 1'b0, 2'b01, 3'b000, 1'b0));
      reset = 1'b0;
      op = 7'b1111111;

      // unknown opcode
      cyc("unk_fetch", fetchV(2'b00));
      cyc("unk_decode", decodeV(2'b00));
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      for (int i = 0; i < 3; i++)
         cyc("unk_trap", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000, 1'b1));
      reset = 1'b1;
      cyc("trap_rst", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 1'b0, 2'b00, 3'b000, 1'b0));
      reset = 1'b0;
      cyc("trap_fetch", fetchV(2'b00));
`else
      cyc("unk_refetch", fetchV(2'b00));
      op = 7'b0000011;
      cyc("unk_next_decode", decodeV(2'b00));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Control unit for the multicycle RISC-V datapath.
- One instruction is sequenced over 3–5 cycles through a Moore state machine. The FSM drives the shared memory, ALU, IR, PC and register-file enables.
- Replaces the single-cycle control unit when the core is built with a unified instruction/data memory.
- Sits beside the datapath. Receives op/f3/f7 from the IR and zero from the ALU.

Parameters:
- STATE_W, 4, width of the state register (11 states used, plus 1 with the optional feature).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- op  input  7  opcode field from the IR
- f3  input  3  funct3 from the IR
- f7  input  7  funct7 from the IR (bit 5 used)
- zero  input  1  ALU zero flag
- pcWrite  output  1  PC register enable
- adrSrc  output  1  memory address mux select: 0=PC, 1=ALUOut
- memWrite  output  1  memory write enable
- irWrite  output  1  IR and oldPC register enable
- resultSrc  output  2  result mux select: 00=ALUOut, 01=Data, 10=ALUResult
- aluSrcA  output  2  ALU A select: 00=PC, 01=oldPC, 10=rs1 (A reg)
- aluSrcB  output  2  ALU B select: 00=rs2 (WriteData reg), 01=imm, 10=const 4
- regWrite  output  1  register-file write enable
- immSrc  output  2  immediate format: 00=I, 01=S, 10=B, 11=J
- aluControl  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
- illegalOp  output  1  illegal-opcode flag (optional feature only; tied 0 otherwise)

Behaviour:
- The state register updates on the rising clk edge.
- Reset:
  - reset=1 at an edge forces state=FETCH, including mid-instruction; the partial instruction is abandoned.
  - While reset=1, pcWrite, memWrite, irWrite and regWrite are forced 0 combinationally.
  - The remaining outputs show their FETCH values.
- Outputs are Moore-decoded from state, with two exceptions:
  - pcWrite = pcUpdate | (branch & zero).
  - immSrc and aluControl decode combinationally from op/f3/f7 and internal aluOp.
- Any output not listed for a state is 0.
- State outputs:
  - FETCH: adrSrc=0, irWrite=1, aluSrcA=00, aluSrcB=10, aluOp=00, resultSrc=10, pcUpdate=1.
  - DECODE: aluSrcA=01, aluSrcB=01, aluOp=00. Precomputes the branch target into ALUOut.
  - MEMADR: aluSrcA=10, aluSrcB=01, aluOp=00.
  - MEMREAD: resultSrc=00, adrSrc=1.
  - MEMWB: resultSrc=01, regWrite=1.
  - MEMWRITE: resultSrc=00, adrSrc=1, memWrite=1.
  - EXECUTER: aluSrcA=10, aluSrcB=00, aluOp=10.
  - EXECUTEI: aluSrcA=10, aluSrcB=01, aluOp=10.
  - ALUWB: resultSrc=00, regWrite=1.
  - BEQ: aluSrcA=10, aluSrcB=00, aluOp=01, resultSrc=00, branch=1.
  - JAL: aluSrcA=01, aluSrcB=10, aluOp=00, resultSrc=00, pcUpdate=1.
- Transitions:
  - FETCH→DECODE.
  - DECODE by op:
    - 0000011 (lw) or 0100011 (sw) → MEMADR
    - 0110011 (R-type) → EXECUTER
    - 0010011 (I-ALU) → EXECUTEI
    - 1100011 → BEQ
    - 1101111 → JAL
    - any other op → FETCH
  - MEMADR→MEMREAD if op=lw, else MEMWRITE.
  - MEMREAD→MEMWB.
  - MEMWB, MEMWRITE and BEQ → FETCH.
  - EXECUTER and EXECUTEI → ALUWB.
  - JAL→ALUWB, which writes the return address oldPC+4.
  - ALUWB→FETCH.
- Latencies: beq 3 cycles; R/I/sw 4; jal 4; lw 5. Unknown op: 2 cycles, no architectural write.
- ALU decode:
  - aluOp 00→add; aluOp 01→sub.
  - aluOp 10 by f3: 000→sub if op[5]&f7[5], else add; 010→slt; 110→or; 111→and; any other f3→add.
- immSrc by op: lw/I-ALU 00, sw 01, beq 10, jal 11; unknown op 00.
- Unused STATE_W encodings → FETCH next cycle.

Optional Feature:
- Macro: MC_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An unknown op in DECODE → TRAP state.
  - TRAP holds all enables at 0 and illegalOp=1.
  - The FSM stays in TRAP until reset.
- Undefined: illegalOp is tied 0; an unknown op returns DECODE→FETCH (a silent NOP).

Decomposition:
- Shared package/header mc_ctrl_defs holds:
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL);
  - state encodings;
  - aluOp and aluControl codes;
  - mux-select codes.
- One sub-module, mc_instr_deco: combinational immSrc and aluControl from op/f3/f7/aluOp.
- The FSM and output decode stay in the top module.

Test Plan:
- Reset: reset=1 for 2 cycles, release → FETCH; cycle 0 shows irWrite=1, pcWrite=1, aluSrcB=10, resultSrc=10.
- lw (op=0000011): state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB → regWrite=1 only in cycle 4, with resultSrc=01; adrSrc=1 in cycle 3; 5 cycles total.
- add vs sub: R-type with f3=000, f7=0100000 → aluControl=001 in EXECUTER, then ALUWB regWrite=1. Repeat with f7=0 → aluControl=000.
- beq: zero=1 in BEQ → pcWrite=1 and aluControl=001. With zero=0 → pcWrite=0; back to FETCH either way; 3 cycles.
- Reset mid-instruction: sw with reset=1 asserted during MEMADR → no memWrite pulse ever; FETCH follows reset release.
- Unknown op=1111111: without the macro, FETCH after DECODE with no enable pulses. With MC_CTRL_ILLEGAL_TRAP_EN, illegalOp=1 persists until reset.
